// File: rtl/scan_display_n_pkg.sv
// scan_display_n_pkg: FSM state encoding and hex glyph table for the multiplexed 7-segment scanner.
// Glyph bits are gfedcba, active-high.
`default_nettype none

package scan_display_n_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } scan_state_e;

   function automatic logic [6:0] hex_glyph(input logic [3:0] val);
      logic [6:0] g;
      case (val)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational hex-to-7-segment decoder with blanking and output polarity.
`default_nettype none

module seg7_hex_dec
   import scan_display_n_pkg::*;
#(
   parameter int ACT_HIGH = 1
)
(
   input  logic [3:0] val_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   logic [6:0] glyph_d;

   always_comb begin
      glyph_d = blank_i ? 7'h00 : hex_glyph(val_i);
      seg_o   = (ACT_HIGH != 0) ? glyph_d : ~glyph_d;
   end

endmodule

`default_nettype wire

// File: rtl/scan_display_n.sv
// scan_display_n: NUM_DIGITS-wide multiplexed 7-segment driver with blanking, PWM brightness,
// leading-zero suppression and per-frame input snapshots. All pins registered.
`default_nettype none

module scan_display_n
   import scan_display_n_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 8,
   parameter int DIG_ACT_HIGH = 1,
   parameter int SEG_ACT_HIGH = 1
)
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    EN,
   input  logic [4*NUM_DIGITS-1:0] DIGITS,
   input  logic [NUM_DIGITS-1:0]   DP_IN,
   input  logic                    LZ_EN,
   input  logic [3:0]              BRIGHT,
   output logic                    A,
   output logic                    B,
   output logic                    C,
   output logic                    D,
   output logic                    E,
   output logic                    F,
   output logic                    G,
   output logic                    DP,
   output logic [NUM_DIGITS-1:0]   DIG,
   output logic                    FRAME_DONE
);

   localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam scan_state_e        SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;
   localparam logic               DIG_OFF    = (DIG_ACT_HIGH == 0);
   localparam logic               SEG_OFF    = (SEG_ACT_HIGH == 0);

   scan_state_e               state_q;
   logic [SLOT_W-1:0]         slot_q;
   logic [PRESC_W-1:0]        presc_q;
   logic [3:0]                pwm_q;
   logic [4*NUM_DIGITS-1:0]   snap_dig_q;
   logic [NUM_DIGITS-1:0]     snap_dp_q;
   logic                      snap_lz_q;
   logic [6:0]                seg_q;
   logic                      dp_q;
   logic [NUM_DIGITS-1:0]     dig_q;
   logic                      fd_q;

   logic [3:0]                cur_val_d;
   logic                      cur_dp_d;
   logic                      cur_sup_d;
   logic [6:0]                seg_d;
   logic                      dp_d;
   logic [NUM_DIGITS-1:0]     dig_d;
   logic                      fd_d;

   // Suppressed iff LZ enabled, not digit 0, and every digit from this slot upward is zero.
   always_comb begin
      cur_val_d = 4'h0;
      cur_dp_d  = 1'b0;
      cur_sup_d = snap_lz_q && (slot_q != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k == int'(slot_q)) begin
            cur_val_d = snap_dig_q[4*k +: 4];
            cur_dp_d  = snap_dp_q[k];
         end
         if (k >= int'(slot_q) && snap_dig_q[4*k +: 4] != 4'h0)
            cur_sup_d = 1'b0;
      end
   end

   seg7_hex_dec #(
      .ACT_HIGH (SEG_ACT_HIGH)
   ) u_dec (
      .val_i   (cur_val_d),
      .blank_i (state_q != ST_ON || cur_sup_d),
      .seg_o   (seg_d)
   );

   // A suppressed digit still lights its DIG when its decimal point must be shown.
   always_comb begin
      dp_d  = ((state_q == ST_ON) && cur_dp_d) ^ SEG_OFF;
      dig_d = {NUM_DIGITS{DIG_OFF}};
      if (state_q == ST_ON && pwm_q <= BRIGHT && (!cur_sup_d || cur_dp_d))
         dig_d = (NUM_DIGITS'(1) << slot_q) ^ {NUM_DIGITS{DIG_OFF}};
      fd_d  = (state_q == ST_ON) && (presc_q == PRESC_LAST) && (slot_q == SLOT_LAST);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         slot_q     <= '0;
         presc_q    <= '0;
         pwm_q      <= 4'h0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         snap_lz_q  <= 1'b0;
         seg_q      <= {7{SEG_OFF}};
         dp_q       <= SEG_OFF;
         dig_q      <= {NUM_DIGITS{DIG_OFF}};
         fd_q       <= 1'b0;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         dig_q <= dig_d;
         fd_q  <= fd_d;
         if (!EN) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  snap_dig_q <= DIGITS;
                  snap_dp_q  <= DP_IN;
                  snap_lz_q  <= LZ_EN;
                  slot_q     <= '0;
                  presc_q    <= '0;
                  pwm_q      <= 4'h0;
                  state_q    <= SLOT_START;
               end
               ST_BLANK: begin
                  presc_q <= presc_q + 1'b1;
                  if (presc_q == BLANK_LAST) begin
                     pwm_q   <= 4'h0;
                     state_q <= ST_ON;
                  end
               end
               ST_ON: begin
                  pwm_q <= pwm_q + 1'b1;
                  if (presc_q == PRESC_LAST) begin
                     presc_q <= '0;
                     pwm_q   <= 4'h0;
                     state_q <= SLOT_START;
                     if (slot_q == SLOT_LAST) begin
                        slot_q     <= '0;
                        snap_dig_q <= DIGITS;
                        snap_dp_q  <= DP_IN;
                        snap_lz_q  <= LZ_EN;
                     end else begin
                        slot_q <= slot_q + 1'b1;
                     end
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign {G, F, E, D, C, B, A} = seg_q;
   assign DP         = dp_q;
   assign DIG        = dig_q;
   assign FRAME_DONE = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_display_n.sv
// tb_scan_display_n: directed and randomized checks of scan_display_n against a time-based
// reference model (slot/phase derived from cycles elapsed since frame start).
`default_nettype none

module tb_scan_display_n;

   localparam int N  = 4;
   localparam int SD = 34;
   localparam int BL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] digits = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        lz_en = 1'b0;
   logic [3:0]  bright = 4'hF;
   logic        a, b, c, d, e, f, g, dp, fd;
   logic [3:0]  dig;

   scan_display_n #(
      .NUM_DIGITS   (N),
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BL),
      .DIG_ACT_HIGH (1),
      .SEG_ACT_HIGH (1)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .EN         (en),
      .DIGITS     (digits),
      .DP_IN      (dp_in),
      .LZ_EN      (lz_en),
      .BRIGHT     (bright),
      .A          (a),
      .B          (b),
      .C          (c),
      .D          (d),
      .E          (e),
      .F          (f),
      .G          (g),
      .DP         (dp),
      .DIG        (dig),
      .FRAME_DONE (fd)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [6:0]  glyph [16];

   // Reference model state: running flag, cycles since frame start, frame snapshot.
   bit          m_run = 1'b0;
   int          m_t = 0;
   logic [15:0] m_snap = 16'h0;
   logic [3:0]  m_dp = 4'h0;
   bit          m_lz = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic step();
      logic [3:0] e_dig;
      logic [6:0] e_seg;
      logic       e_dp, e_fd, sup;
      int         phase, sl;
      @(posedge clk);
      e_dig = 4'h0; e_seg = 7'h00; e_dp = 1'b0; e_fd = 1'b0;
      if (!rst && m_run) begin
         phase = m_t % SD;
         sl    = m_t / SD;
         e_fd  = (m_t == N*SD - 1);
         if (phase >= BL) begin
            sup = m_lz && (sl > 0);
            for (int k = sl; k < N; k++)
               if (m_snap[4*k +: 4] != 4'h0) sup = 1'b0;
            e_seg = sup ? 7'h00 : glyph[m_snap[4*sl +: 4]];
            e_dp  = m_dp[sl];
            if (((phase - BL) % 16) <= int'(bright) && (!sup || e_dp))
               e_dig = 4'(1 << sl);
         end
      end
      if (rst || !en) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         m_run = 1'b1; m_t = 0; m_snap = digits; m_dp = dp_in; m_lz = lz_en;
      end else begin
         m_t++;
         if (m_t == N*SD) begin
            m_t = 0; m_snap = digits; m_dp = dp_in; m_lz = lz_en;
         end
      end
      #1;
      chk("dig", 32'(dig), 32'(e_dig));
      chk("seg", 32'({g, f, e, d, c, b, a}), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame_done", 32'(fd), 32'(e_fd));
   endtask

   task automatic restart();
      en = 1'b0;
      step();
      step();
      en = 1'b1;
      step();
   endtask

   initial begin
      int cnt, first, second;
      glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

      // Reset held three cycles
      repeat (3) step();
      chk("rst_dig", 32'(dig), 32'h0);
      chk("rst_seg", 32'({g, f, e, d, c, b, a}), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_fd", 32'(fd), 32'h0);
      rst = 1'b0;

      // Basic scan of 1234 with frame-done spacing
      digits = 16'h1234; bright = 4'hF;
      restart();
      first = -1; second = -1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (fd && first < 0) first = i;
         else if (fd && second < 0) second = i;
      end
      chk("fd_first", 32'(first), 32'd136);
      chk("fd_period", 32'(second - first), 32'd136);

      // Leading-zero suppression
      lz_en = 1'b1; digits = 16'h0050;
      restart();
      repeat (40) step();
      chk("lz_slot1_seg", 32'({g, f, e, d, c, b, a}), 32'h6D);
      chk("lz_slot1_dig", 32'(dig), 32'b0010);
      repeat (68) step();
      chk("lz_slot3_dig", 32'(dig), 32'h0);
      chk("lz_slot3_seg", 32'({g, f, e, d, c, b, a}), 32'h0);
      digits = 16'h0000; dp_in = 4'b0100;
      repeat (300) step();
      dp_in = 4'h0; lz_en = 1'b0;

      // Tear-free snapshot: change mid-frame
      digits = 16'h1111;
      restart();
      repeat (50) step();
      digits = 16'h2222;
      repeat (250) step();

      // PWM brightness
      digits = 16'h8888; bright = 4'd3;
      restart();
      cnt = 0;
      for (int i = 0; i < 138; i++) begin step(); if (dig != 4'h0) cnt++; end
      chk("pwm_b3_on", 32'(cnt), 32'd32);
      bright = 4'd0;
      restart();
      cnt = 0;
      for (int i = 0; i < 138; i++) begin step(); if (dig != 4'h0) cnt++; end
      chk("pwm_b0_on", 32'(cnt), 32'd8);

      // EN drop mid slot 2, then restart
      digits = 16'h1234; bright = 4'hF;
      restart();
      repeat (78) step();
      en = 1'b0;
      step();
      chk("en_drop_still", 32'(dig), 32'b0100);
      step();
      chk("en_drop_dig", 32'(dig), 32'h0);
      chk("en_drop_seg", 32'({g, f, e, d, c, b, a}), 32'h0);
      en = 1'b1;
      step();
      repeat (3) step();
      chk("restart_dig", 32'(dig), 32'b0001);

      // Reset mid-frame
      repeat (50) step();
      rst = 1'b1;
      step();
      chk("rst_mid_dig", 32'(dig), 32'h0);
      chk("rst_mid_fd", 32'(fd), 32'h0);
      rst = 1'b0;

      // Randomized traffic
      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < N; k++)
            digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         dp_in  = 4'($urandom_range(0, 15));
         lz_en  = 1'($urandom_range(0, 1));
         bright = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) en = ~en;
         else en = 1'b1;
         for (int i = 0; i < int'($urandom_range(20, 300)); i++) begin
            step();
            rst = 1'b0;
            if ($urandom_range(0, 7) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
         end
         rst = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
